// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA raster counters, sync pulses and active-video flag.
// Sync/active are delayed PIPE_DELAY clks to line up with registered overlay pixels.
module vga_timing_gen #(
   parameter int H_VISIBLE  = 800,
   parameter int H_FP       = 56,
   parameter int H_SYNC     = 120,
   parameter int H_BP       = 64,
   parameter int V_VISIBLE  = 600,
   parameter int V_FP       = 37,
   parameter int V_SYNC     = 6,
   parameter int V_BP       = 23,
   parameter int H_POL      = 1,
   parameter int V_POL      = 1,
   parameter int CLK_DIV    = 1,
   parameter int PIPE_DELAY = 1
) (
   input  logic        clk,
   input  logic        reset_n,
   output logic [10:0] vga_h,
   output logic [10:0] vga_v,
   output logic        hsync,
   output logic        vsync,
   output logic        active,
   output logic        pixel_tick,
   output logic        frame_start
);

   localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

   localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
   localparam logic [10:0] V_LAST     = 11'(V_TOTAL - 1);
   localparam logic [10:0] H_VIS      = 11'(H_VISIBLE);
   localparam logic [10:0] V_VIS      = 11'(V_VISIBLE);
   localparam logic [10:0] HS_START   = 11'(H_VISIBLE + H_FP);
   localparam logic [10:0] HS_END     = 11'(H_VISIBLE + H_FP + H_SYNC);
   localparam logic [10:0] VS_START   = 11'(V_VISIBLE + V_FP);
   localparam logic [10:0] VS_END     = 11'(V_VISIBLE + V_FP + V_SYNC);
   localparam logic [3:0]  DIV_LAST   = 4'(CLK_DIV - 1);
   localparam logic        H_ACT      = 1'(H_POL);
   localparam logic        V_ACT      = 1'(V_POL);

   logic [3:0]  r_div;
   logic [10:0] r_h;
   logic [10:0] r_v;
   logic        r_pixel_tick;
   logic        r_frame_start;

   logic w_tick;
   logic w_h_sync_raw;
   logic w_v_sync_raw;
   logic w_act_raw;
   logic w_hsync_lvl;
   logic w_vsync_lvl;

   assign w_tick = (r_div == DIV_LAST);

   // Line wrap and frame wrap happen on the same tick as a single event.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_div         <= 4'd0;
         r_h           <= 11'd0;
         r_v           <= 11'd0;
         r_pixel_tick  <= 1'b0;
         r_frame_start <= 1'b0;
      end else begin
         r_pixel_tick  <= w_tick;
         r_frame_start <= 1'b0;
         if (w_tick) begin
            r_div <= 4'd0;
            if (r_h == H_LAST) begin
               r_h <= 11'd0;
               if (r_v == V_LAST) begin
                  r_v           <= 11'd0;
                  r_frame_start <= 1'b1;
               end else begin
                  r_v <= r_v + 11'd1;
               end
            end else begin
               r_h <= r_h + 11'd1;
            end
         end else begin
            r_div <= r_div + 4'd1;
         end
      end
   end

   assign w_h_sync_raw = (r_h >= HS_START) && (r_h < HS_END);
   assign w_v_sync_raw = (r_v >= VS_START) && (r_v < VS_END);
   assign w_act_raw    = (r_h < H_VIS) && (r_v < V_VIS);
   assign w_hsync_lvl  = w_h_sync_raw ? H_ACT : ~H_ACT;
   assign w_vsync_lvl  = w_v_sync_raw ? V_ACT : ~V_ACT;

   generate
      if (PIPE_DELAY == 0) begin : g_nopipe
         // Held inactive during reset, matching the piped variants.
         assign hsync  = reset_n ? w_hsync_lvl : ~H_ACT;
         assign vsync  = reset_n ? w_vsync_lvl : ~V_ACT;
         assign active = reset_n & w_act_raw;
      end else begin : g_pipe
         logic [PIPE_DELAY-1:0] r_hs_pipe;
         logic [PIPE_DELAY-1:0] r_vs_pipe;
         logic [PIPE_DELAY-1:0] r_act_pipe;

         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               r_hs_pipe  <= {PIPE_DELAY{~H_ACT}};
               r_vs_pipe  <= {PIPE_DELAY{~V_ACT}};
               r_act_pipe <= '0;
            end else begin
               r_hs_pipe[0]  <= w_hsync_lvl;
               r_vs_pipe[0]  <= w_vsync_lvl;
               r_act_pipe[0] <= w_act_raw;
               for (int i = 1; i < PIPE_DELAY; i++) begin
                  r_hs_pipe[i]  <= r_hs_pipe[i-1];
                  r_vs_pipe[i]  <= r_vs_pipe[i-1];
                  r_act_pipe[i] <= r_act_pipe[i-1];
               end
            end
         end

         assign hsync  = r_hs_pipe[PIPE_DELAY-1];
         assign vsync  = r_vs_pipe[PIPE_DELAY-1];
         assign active = r_act_pipe[PIPE_DELAY-1];
      end
   endgenerate

   assign vga_h       = r_h;
   assign vga_v       = r_v;
   assign pixel_tick  = r_pixel_tick;
   assign frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - scoreboard bench for vga_timing_gen over three small raster configs.
// Expected outputs come from tick-count arithmetic; random reset pulses interrupt the raster.
module tb_vga_timing_gen;

   typedef struct packed {
      logic [10:0] h;
      logic [10:0] v;
      logic        hs;
      logic        vs;
      logic        act;
      logic        pt;
      logic        fs;
   } obs_t;

   logic clk = 1'b0;
   logic reset_n;
   always #5 clk = ~clk;

   logic [10:0] o_h   [3];
   logic [10:0] o_v   [3];
   logic        o_hs  [3];
   logic        o_vs  [3];
   logic        o_act [3];
   logic        o_pt  [3];
   logic        o_fs  [3];

   vga_timing_gen #(
      .H_VISIBLE(10), .H_FP(3), .H_SYNC(4), .H_BP(2),
      .V_VISIBLE(6),  .V_FP(2), .V_SYNC(3), .V_BP(1),
      .H_POL(1), .V_POL(1), .CLK_DIV(1), .PIPE_DELAY(1)
   ) dut0 (
      .clk(clk), .reset_n(reset_n), .vga_h(o_h[0]), .vga_v(o_v[0]),
      .hsync(o_hs[0]), .vsync(o_vs[0]), .active(o_act[0]),
      .pixel_tick(o_pt[0]), .frame_start(o_fs[0])
   );

   vga_timing_gen #(
      .H_VISIBLE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
      .V_VISIBLE(5), .V_FP(1), .V_SYNC(2), .V_BP(2),
      .H_POL(0), .V_POL(0), .CLK_DIV(2), .PIPE_DELAY(0)
   ) dut1 (
      .clk(clk), .reset_n(reset_n), .vga_h(o_h[1]), .vga_v(o_v[1]),
      .hsync(o_hs[1]), .vsync(o_vs[1]), .active(o_act[1]),
      .pixel_tick(o_pt[1]), .frame_start(o_fs[1])
   );

   vga_timing_gen #(
      .H_VISIBLE(6), .H_FP(2), .H_SYNC(2), .H_BP(2),
      .V_VISIBLE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
      .H_POL(1), .V_POL(0), .CLK_DIV(16), .PIPE_DELAY(4)
   ) dut2 (
      .clk(clk), .reset_n(reset_n), .vga_h(o_h[2]), .vga_v(o_v[2]),
      .hsync(o_hs[2]), .vsync(o_vs[2]), .active(o_act[2]),
      .pixel_tick(o_pt[2]), .frame_start(o_fs[2])
   );

   int errors = 0;
   int checks = 0;
   int k      = 0;
   int cyc    = 0;
   obs_t q0[$];
   obs_t q1[$];
   obs_t q2[$];

   // k = clock edges seen since reset release; the raster position is pure arithmetic on k.
   function automatic obs_t model(int i, int kk, logic rn);
      int hv, hf, hsw, hb, vv, vf, vsw, vb, hp, vp, cd, pd;
      int ht, vt, ft, t, pos, t2, p2, h2, v2;
      logic hpl, vpl;
      obs_t m;
      case (i)
         0:       begin hv=10; hf=3; hsw=4; hb=2; vv=6; vf=2; vsw=3; vb=1; hp=1; vp=1; cd=1;  pd=1; end
         1:       begin hv=8;  hf=2; hsw=3; hb=3; vv=5; vf=1; vsw=2; vb=2; hp=0; vp=0; cd=2;  pd=0; end
         default: begin hv=6;  hf=2; hsw=2; hb=2; vv=4; vf=1; vsw=2; vb=1; hp=1; vp=0; cd=16; pd=4; end
      endcase
      hpl = hp[0];
      vpl = vp[0];
      ht = hv + hf + hsw + hb;
      vt = vv + vf + vsw + vb;
      ft = ht * vt;
      if (!rn) begin
         m.h = '0; m.v = '0; m.pt = 1'b0; m.fs = 1'b0;
         m.hs = ~hpl; m.vs = ~vpl; m.act = 1'b0;
         return m;
      end
      t    = kk / cd;
      pos  = t % ft;
      m.h  = 11'(pos % ht);
      m.v  = 11'(pos / ht);
      m.pt = (kk > 0) && (kk % cd == 0);
      m.fs = m.pt && (pos == 0);
      if (kk < pd) begin
         m.hs = ~hpl; m.vs = ~vpl; m.act = 1'b0;
      end else begin
         t2 = (kk - pd) / cd;
         p2 = t2 % ft;
         h2 = p2 % ht;
         v2 = p2 / ht;
         m.hs  = (h2 >= hv + hf && h2 < hv + hf + hsw) ? hpl : ~hpl;
         m.vs  = (v2 >= vv + vf && v2 < vv + vf + vsw) ? vpl : ~vpl;
         m.act = (h2 < hv) && (v2 < vv);
      end
      return m;
   endfunction

   // Expectation producer: runs after any reset change of this cycle has been driven.
   always begin
      logic rn_at_edge;
      @(posedge clk);
      rn_at_edge = reset_n;
      #3;
      cyc++;
      if (!rn_at_edge) k = 0;
      else             k++;
      q0.push_back(model(0, k, reset_n));
      q1.push_back(model(1, k, reset_n));
      q2.push_back(model(2, k, reset_n));
   end

   // Monitor: every cycle each DUT presents a sample, compared against the queued expectation.
   always @(negedge clk) begin
      for (int i = 0; i < 3; i++) begin
         obs_t e, a;
         int   n;
         a = '{h: o_h[i], v: o_v[i], hs: o_hs[i], vs: o_vs[i], act: o_act[i], pt: o_pt[i], fs: o_fs[i]};
         n = (i == 0) ? q0.size() : (i == 1) ? q1.size() : q2.size();
         checks++;
         if (n == 0) begin
            errors++;
            $display("FAIL dut%0d_noexp cyc=%0d expectation queue empty", i, cyc);
         end else begin
            if (i == 0)      e = q0.pop_front();
            else if (i == 1) e = q1.pop_front();
            else             e = q2.pop_front();
            if (a !== e) begin
               errors++;
               $display("FAIL dut%0d_raster cyc=%0d got h=%0d v=%0d hs=%b vs=%b act=%b pt=%b fs=%b want h=%0d v=%0d hs=%b vs=%b act=%b pt=%b fs=%b",
                        i, cyc, a.h, a.v, a.hs, a.vs, a.act, a.pt, a.fs,
                        e.h, e.v, e.hs, e.vs, e.act, e.pt, e.fs);
            end
         end
      end
   end

   task automatic pulse_reset(int n);
      @(posedge clk);
      #2 reset_n = 1'b0;
      repeat (n) @(posedge clk);
      #2 reset_n = 1'b1;
   endtask

   initial begin
      reset_n = 1'b0;
      repeat (5) @(posedge clk);
      #2 reset_n = 1'b1;
      repeat (3300) @(posedge clk);
      for (int n = 0; n < 8; n++) begin
         pulse_reset($urandom_range(1, 4));
         repeat ($urandom_range(20, 1200)) @(posedge clk);
      end
      pulse_reset(3);
      repeat (3300) @(posedge clk);
      @(negedge clk);
      #1;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
